// File: rtl/aes_pkg.sv
// aes_pkg: AES byte type, GF(2^8) arithmetic and the SubBytes affine transforms.
// Shared by the S-box core and the SubBytes pipeline.
package aes_pkg;

  localparam logic [7:0] AES_POLY     = 8'h1B;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] AFFINE_INV_C = 8'h05;

  typedef logic [7:0] byte_t;

  function automatic byte_t rotl(byte_t x, int k);
    byte_t r;
    r = x;
    for (int i = 0; i < 8; i++) begin
      if (i < k) r = {r[6:0], r[7]};
    end
    return r;
  endfunction

  function automatic byte_t xtime(byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; 0 maps to 0 without special casing.
  function automatic byte_t gf_inv(byte_t x);
    byte_t x3;
    byte_t x7;
    byte_t x15;
    byte_t x31;
    byte_t x63;
    byte_t x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic byte_t affine_fwd(byte_t x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ AFFINE_C;
  endfunction

  function automatic byte_t affine_inv(byte_t x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ AFFINE_INV_C;
  endfunction

endpackage

// File: rtl/aes_sbox_core.sv
// aes_sbox_core: single-byte forward/inverse AES S-box, purely combinational.
// One GF inverter is shared by both directions; only the affine step moves.
module aes_sbox_core
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] c
);

  byte_t w_pre;
  byte_t w_gf;

  always_comb begin
    w_pre = inv ? affine_inv(a) : a;
    w_gf  = gf_inv(w_pre);
    c     = inv ? w_gf : affine_fwd(w_gf);
  end

endmodule

// File: rtl/aes_subbytes_pipe.sv
// aes_subbytes_pipe: LANES-wide pipelined SubBytes/InvSubBytes with valid/ready flow control.
// Define AES_SUBBYTES_CNT_EN to add the beat_cnt output-transfer counter.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES       = 16,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
`ifdef AES_SUBBYTES_CNT_EN
  output logic [31:0]          beat_cnt,
`endif
  output logic                 busy
);

  localparam int unsigned W = 8 * LANES;

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_subbytes_pipe: LANES must be 1..16");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("aes_subbytes_pipe: PIPE_STAGES must be 1..3");
  end

  logic [W-1:0] w_sub;

  // Whole S-box sits ahead of stage 1; deeper stages only add register slack.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_core u_sbox (
      .a   (in_data[8*i +: 8]),
      .inv (in_inv),
      .c   (w_sub[8*i +: 8])
    );
  end

  logic [PIPE_STAGES-1:0]        r_valid;
  logic [PIPE_STAGES-1:0][W-1:0] r_data;
  logic [PIPE_STAGES-1:0]        r_inv;
  logic [PIPE_STAGES-1:0]        w_ld;

  // A stage may load if any stage from it to the output is empty, or the sink accepts.
  always_comb begin
    logic hole;
    hole = out_ready;
    w_ld = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      hole    = hole || !r_valid[k];
      w_ld[k] = hole;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_inv   <= '0;
    end else begin
      if (w_ld[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_sub;
          r_inv[0]  <= in_inv;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_ld[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_inv[k]  <= r_inv[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_valid[PIPE_STAGES-1];
  assign out_data  = r_data[PIPE_STAGES-1];
  assign out_inv   = r_inv[PIPE_STAGES-1];
  assign busy      = |r_valid;

`ifdef AES_SUBBYTES_CNT_EN
  logic [31:0] r_beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// tb_aes_subbytes_pipe: scoreboard bench for aes_subbytes_pipe, reference S-box from log/antilog tables.
// Covers latency, round trip, streaming, backpressure, async reset and (AES_SUBBYTES_CNT_EN) beat_cnt.
module tb_aes_subbytes_pipe;

  localparam int unsigned LANES       = 16;
  localparam int unsigned PIPE_STAGES = 2;
  localparam int unsigned W           = 8 * LANES;

  typedef struct packed {
    logic         inv;
    logic [W-1:0] data;
  } beat_t;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data   = '0;
  logic         in_inv    = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_inv;
  logic         busy;
`ifdef AES_SUBBYTES_CNT_EN
  logic [31:0]  beat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int first_out = -1;
  int last_out  = -1;

  logic [7:0] sbox     [256];
  logic [7:0] sbox_inv [256];
  logic [7:0] ex       [256];
  logic [7:0] lg       [256];
  beat_t      exp_q    [$];

  aes_subbytes_pipe #(
    .LANES       (LANES),
    .PIPE_STAGES (PIPE_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inv   (out_inv),
`ifdef AES_SUBBYTES_CNT_EN
    .beat_cnt  (beat_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
    n_checks++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, req);
  endtask

  // Reference S-box via generator-3 log tables, independent of the x^254 chain.
  task automatic build_model();
    logic [7:0] e;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] c;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = 8'(i);
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      g = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
      for (int i = 0; i < 8; i++)
        b[i] = g[i] ^ g[(i+4)%8] ^ g[(i+5)%8] ^ g[(i+6)%8] ^ g[(i+7)%8] ^ c[i];
      sbox[x]     = b;
      sbox_inv[b] = 8'(x);
    end
  endtask

  function automatic logic [W-1:0] model(logic [W-1:0] d, logic inv);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = inv ? sbox_inv[d[8*l +: 8]] : sbox[d[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back({in_inv, model(in_data, in_inv)});
      if (out_valid && out_ready) begin
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        check_eq("sb_nonempty", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e.data);
          check_eq("out_inv", W'(out_inv), W'(e.inv));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 200);
    if (!in_ready) check_eq("accept_timeout", W'(in_ready), W'(1));
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = rand_beat();
    in_inv   = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < 500) begin
      tick();
      n++;
    end
    check_eq("drain_sb_empty", W'(exp_q.size()), W'(0));
    check_eq("drain_idle", W'(busy), W'(0));
  endtask

  task automatic wait_out(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int w;
    int k;
    int n0;
    int stalls;
    logic [W-1:0] d;
    logic [W-1:0] held;
    logic         held_inv;

    build_model();

    #2;
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_inv", W'(out_inv), W'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", W'(in_ready), W'(1));

    // Known forward values and exact latency.
    d = rand_beat();
    d[47:0] = 48'h9AB4_7B5C_5300;
    send(d, 1'b0, w);
    idle();
    wait_out(k);
    check_eq("fwd_latency", W'(k), W'(PIPE_STAGES));
    check_eq("fwd_lanes", W'(out_data[47:0]), W'(48'hB88D_214A_ED63));
    check_eq("fwd_inv_flag", W'(out_inv), W'(0));
    drain();

    // Known inverse values.
    d = rand_beat();
    d[31:0] = 32'h214A_ED63;
    send(d, 1'b1, w);
    idle();
    wait_out(k);
    check_eq("inv_latency", W'(k), W'(PIPE_STAGES));
    check_eq("inv_lanes", W'(out_data[31:0]), W'(32'h7B5C_5300));
    check_eq("inv_inv_flag", W'(out_inv), W'(1));
    drain();

    // All 256 bytes forward, then their images back through the inverse.
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 16; l++) d[8*l +: 8] = 8'(16 * b + l);
      send(d, 1'b0, w);
    end
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 16; l++) d[8*l +: 8] = sbox[16 * b + l];
      send(d, 1'b1, w);
    end
    idle();
    drain();

    // Streaming, alternating direction.
    first_out = -1;
    n0 = n_out;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      send(rand_beat(), 1'(i % 2), w);
      stalls += w - 1;
    end
    idle();
    drain();
    check_eq("stream_stalls", W'(stalls), W'(0));
    check_eq("stream_count", W'(n_out - n0), W'(20));
    check_eq("stream_rate", W'(last_out - first_out), W'(19));

    // Backpressure with the pipe full.
    n0 = n_out;
    out_ready = 1'b0;
    stalls = 0;
    for (int i = 0; i < int'(PIPE_STAGES); i++) begin
      send(rand_beat(), 1'(i % 2), w);
      stalls += w - 1;
    end
    check_eq("bp_fill_stalls", W'(stalls), W'(0));
    in_data = rand_beat();
    in_inv  = 1'b1;
    @(negedge clk);
    held     = out_data;
    held_inv = out_inv;
    check_eq("bp_in_ready", W'(in_ready), W'(0));
    check_eq("bp_out_valid", W'(out_valid), W'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_data_stable", out_data, held);
      check_eq("bp_inv_stable", W'(out_inv), W'(held_inv));
      check_eq("bp_hold_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    idle();
    drain();
    check_eq("bp_count", W'(n_out - n0), W'(PIPE_STAGES + 1));

    // Asynchronous reset with beats in flight.
    send(rand_beat(), 1'b0, w);
    send(rand_beat(), 1'b1, w);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", W'(out_valid), W'(0));
    check_eq("arst_busy", W'(busy), W'(0));
    check_eq("arst_out_data", out_data, '0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_in_ready", W'(in_ready), W'(1));
    tick();
    send(rand_beat(), 1'b1, w);
    idle();
    drain();

`ifdef AES_SUBBYTES_CNT_EN
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      send(rand_beat(), 1'(i % 2), w);
      idle();
      tick();
      tick();
      out_ready = 1'b1;
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      send(rand_beat(), 1'b0, w);
      idle();
      drain();
    end
    check_eq("cnt_seven", W'(beat_cnt), W'(7));
    force dut.r_beat_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.r_beat_cnt;
    check_eq("cnt_preload", W'(beat_cnt), W'(32'hFFFF_FFFF));
    send(rand_beat(), 1'b1, w);
    idle();
    drain();
    check_eq("cnt_wrap", W'(beat_cnt), W'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
